// File: rtl/irq_request_encoder.sv
// Captures rising edges on asynchronous interrupt lines and issues them one at a time,
// lowest index first, as single-cycle flag-set pulses to the interrupt controller.
module irq_request_encoder #(
    parameter int unsigned NUM_INT = 16,
    localparam int unsigned ADDR_SIZE = $clog2(NUM_INT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_INT-1:0]   irq_in,
    input  logic                 sw_access,
    input  logic                 clr_overrun,
    output logic                 ifr_set_flag,
    output logic [ADDR_SIZE:0]   reg_addr,
    output logic [NUM_INT-1:0]   pending,
    output logic [NUM_INT-1:0]   overrun
);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   idx_q, idx_d;

    logic [NUM_INT-1:0]     s1_q, s2_q, s3_q, s3_d;
    logic [1:0]             warm_q, warm_d;
    logic [NUM_INT-1:0]     pending_q, pending_d;
    logic [NUM_INT-1:0]     overrun_q, overrun_d;

    logic [NUM_INT-1:0]     irq_edge;
    logic [NUM_INT-1:0]     claim;
    logic [NUM_INT-1:0]     ovr_set;
    logic                   claim_en;
    logic [ADDR_SIZE-1:0]   low_idx;

    // Synchronizer and history stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            warm_q <= '0;
        end else begin
            s1_q   <= irq_in;
            s2_q   <= s1_q;
            s3_q   <= s3_d;
            warm_q <= warm_d;
        end
    end

    // For the first two edges after reset the history flop loads what s2 is about to hold,
    // so a line already high at release never looks like a fresh rising edge.
    always_comb begin
        warm_d   = {warm_q[0], 1'b1};
        s3_d     = warm_q[1] ? s2_q : s1_q;
        irq_edge = s2_q & ~s3_q;
    end

    // Lowest pending index wins.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = ADDR_SIZE'(i);
            end
        end
    end

    always_comb begin
        claim_en = (state_q == StIdle) && (pending_q != '0) && !sw_access;
        claim    = claim_en ? (NUM_INT'(1) << low_idx) : '0;
    end

    // A new edge on the claimed line re-arms it; an edge on a line still waiting is lost.
    always_comb begin
        ovr_set   = irq_edge & pending_q & ~claim;
        pending_d = (pending_q & ~claim) | irq_edge;
        overrun_d = (clr_overrun ? '0 : overrun_q) | ovr_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (claim_en) begin
                    state_d = StIssue;
                    idx_d   = low_idx;
                end
            end
            StIssue: begin
                if (!sw_access) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ifr_set_flag = (state_q == StIssue) && !sw_access;
        reg_addr     = {1'b0, idx_q};
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule
